// File: rtl/poly_tone_synth_if.sv
// Sequencer-to-synth bundle: channel config writes and key gates in, envelope activity and stereo PCM out.
// No handshake: config is a one-cycle write strobe and the outputs are free-running samples.
interface poly_tone_synth_if #(
    parameter int NCH   = 4,
    parameter int DIV_W = 22,
    parameter int VOL_W = 4,
    parameter int AUD_W = 16
) ();
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic                    cfg_we;
    logic [CH_W-1:0]         cfg_ch;
    logic [DIV_W-1:0]        cfg_div;
    logic [VOL_W-1:0]        cfg_vol;
    logic [1:0]              cfg_pan;
    logic [NCH-1:0]          key_on;
    logic [NCH-1:0]          active;
    logic signed [AUD_W-1:0] audio_left;
    logic signed [AUD_W-1:0] audio_right;

    modport master (
        output cfg_we, cfg_ch, cfg_div, cfg_vol, cfg_pan, key_on,
        input  active, audio_left, audio_right
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, cfg_vol, cfg_pan, key_on,
        output active, audio_left, audio_right
    );
endinterface

// File: rtl/poly_tone_synth.sv
// Multi-channel square-wave synth: per-channel divider, envelope, pan; saturating stereo mix.
// Outputs registered one cycle after the phase/envelope change; no backpressure, one config write per cycle.
module poly_tone_synth #(
    parameter int          NCH      = 4,
    parameter int          DIV_W    = 22,
    parameter int          VOL_W    = 4,
    parameter int          AUD_W    = 16,
    parameter int unsigned AMP_STEP = 32'h0000_0800,
    parameter int          ENV_DIV  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    poly_tone_synth_if.slave bus
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ACC_W = AUD_W + $clog2(NCH) + 1;
    localparam int PRE_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2**(AUD_W-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;

    logic [DIV_W-1:0]        r_cnt    [NCH];
    logic [DIV_W-1:0]        r_div    [NCH];
    logic [DIV_W-1:0]        r_shadow [NCH];
    logic [VOL_W-1:0]        r_vol    [NCH];
    logic [VOL_W-1:0]        r_env    [NCH];
    logic [1:0]              r_pan    [NCH];
    logic [NCH-1:0]          r_phase;
    logic [NCH-1:0]          r_active;
    logic [PRE_W-1:0]        r_pre;
    logic signed [AUD_W-1:0] r_left;
    logic signed [AUD_W-1:0] r_right;

    logic                    w_tick;
    logic [NCH-1:0]          w_idle;
    logic signed [ACC_W-1:0] w_smp [NCH];
    logic signed [ACC_W-1:0] w_sum_l;
    logic signed [ACC_W-1:0] w_sum_r;

    assign w_tick = (r_pre == PRE_W'(ENV_DIV - 1));

    // A divider below 2 parks the channel: it contributes nothing to the mix.
    always_comb begin
        w_sum_l = '0;
        w_sum_r = '0;
        for (int i = 0; i < NCH; i++) begin
            w_idle[i] = (r_div[i] < DIV_W'(2));
            w_smp[i]  = w_idle[i] ? '0 : $signed(ACC_W'(r_env[i]) * ACC_W'(AMP_STEP));
            if (r_phase[i]) w_smp[i] = -w_smp[i];
            if (r_pan[i][1]) w_sum_l = w_sum_l + w_smp[i];
            if (r_pan[i][0]) w_sum_r = w_sum_r + w_smp[i];
        end
    end

    function automatic logic signed [AUD_W-1:0] f_sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)      f_sat = SAT_HI[AUD_W-1:0];
        else if (v < SAT_LO) f_sat = SAT_LO[AUD_W-1:0];
        else                 f_sat = v[AUD_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre    <= '0;
            r_phase  <= '0;
            r_active <= '0;
            r_left   <= '0;
            r_right  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i]    <= '0;
                r_div[i]    <= '0;
                r_shadow[i] <= '0;
                r_vol[i]    <= '0;
                r_env[i]    <= '0;
                r_pan[i]    <= '0;
            end
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            r_left  <= f_sat(w_sum_l);
            r_right <= f_sat(w_sum_r);
            for (int i = 0; i < NCH; i++) begin
                r_active[i] <= (r_env[i] != '0);

                // New divider only takes effect at a half-period boundary (or while parked).
                if (w_idle[i]) begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= 1'b0;
                    r_div[i]   <= r_shadow[i];
                end else if (r_cnt[i] == r_div[i]) begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= ~r_phase[i];
                    r_div[i]   <= r_shadow[i];
                end else begin
                    r_cnt[i]   <= r_cnt[i] + 1'b1;
                end

                if (w_tick) begin
                    if (bus.key_on[i]) begin
                        if (r_env[i] < r_vol[i])      r_env[i] <= r_env[i] + 1'b1;
                        else if (r_env[i] > r_vol[i]) r_env[i] <= r_env[i] - 1'b1;
                    end else if (r_env[i] != '0) begin
                        r_env[i] <= r_env[i] - 1'b1;
                    end
                end

                if (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) begin
                    r_shadow[i] <= bus.cfg_div;
                    r_vol[i]    <= bus.cfg_vol;
                    r_pan[i]    <= bus.cfg_pan;
                end
            end
        end
    end

    assign bus.active      = r_active;
    assign bus.audio_left  = r_left;
    assign bus.audio_right = r_right;
endmodule
